// File: rtl/key_debouncer_pkg.sv
// Shared types and defaults for the front-panel key debouncer.
// The state encoding is fixed at 2 bits so every encoding is a named state.
package key_pkg;

   typedef enum logic [1:0] {
      RELEASED  = 2'd0,
      PRESS_CHK = 2'd1,
      PRESSED   = 2'd2,
      REL_CHK   = 2'd3
   } key_state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
   localparam int SYNC_STAGES_DEF     = 2;
   localparam int REPEAT_DELAY_DEF    = 25_000_000;
   localparam int REPEAT_PERIOD_DEF   = 5_000_000;

   // Bits needed to hold values 0..max_count inclusive.
   function automatic int cnt_width(input int max_count);
      return (max_count < 1) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Key-side signal bundle: raw active-low key in, conditioned level and qualifier flag out.
// master drives the key (board/bench side), slave is the debouncer.
interface key_debouncer_if;

   logic KeyN;
   logic Db;
   logic Bouncing;

   modport master (
      output KeyN,
      input  Db,
      input  Bouncing
   );

   modport slave (
      input  KeyN,
      output Db,
      output Bouncing
   );

endinterface

// File: rtl/key_debouncer_sync_chain.sv
// Multi-flop synchroniser for an asynchronous board input, with a
// selectable value loaded on asynchronous reset.
module sync_chain #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic Clk,
   input  logic ResetN,
   input  logic d,
   output logic q
);

   logic [STAGES:0] tap;

   assign tap[0] = d;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         logic q_reg;

         always_ff @(posedge Clk or negedge ResetN) begin
            if (!ResetN) begin
               q_reg <= RST_VAL;
            end else begin
               q_reg <= tap[gi];
            end
         end

         assign tap[gi+1] = q_reg;
      end
   endgenerate

   assign q = tap[STAGES];

endmodule

// File: rtl/key_debouncer.sv
// Push-button conditioner: synchronise, debounce, present an active-high level.
// Optional auto-repeat (one-cycle Db drops while held) under KEY_DEBOUNCE_REPEAT_EN.
module key_debouncer
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic             Clk,
   input  logic             ResetN,
   key_debouncer_if.slave   kif
);

   localparam int CNT_W = cnt_width((DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES
                                                                     : REPEAT_DELAY);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;

   // Empty marker scope: appears in the elaborated hierarchy only for unusable settings.
   generate
      if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2 || REPEAT_PERIOD < 2) begin : g_param_out_of_range
      end
   endgenerate

`ifdef KEY_DEBOUNCE_REPEAT_EN
   localparam logic [CNT_W-1:0] RPT_FIRE   = CNT_W'(REPEAT_DELAY);
   // Reloading DELAY-PERIOD makes the next fire land exactly one period later.
   localparam logic [CNT_W-1:0] RPT_RELOAD = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                             CNT_W'(REPEAT_DELAY - REPEAT_PERIOD) : '0;
   logic rpt_drop;
`endif

   key_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
   logic             db_reg, db_next;
   logic             bouncing_reg, bouncing_next;
   logic             key_sync;
   logic             pressed;

   sync_chain #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_sync (
      .Clk    (Clk),
      .ResetN (ResetN),
      .d      (kif.KeyN),
      .q      (key_sync)
   );

   assign pressed = ~key_sync;
   assign cnt_inc = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + CNT_W'(1);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
`ifdef KEY_DEBOUNCE_REPEAT_EN
      rpt_drop   = 1'b0;
`endif
      case (state_reg)
         RELEASED: begin
            if (pressed) begin
               state_next = PRESS_CHK;
               cnt_next   = '0;
            end
         end
         PRESS_CHK: begin
            if (!pressed) begin
               state_next = RELEASED;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = PRESSED;
               cnt_next   = '0;
            end else begin
               cnt_next   = cnt_inc;
            end
         end
         PRESSED: begin
            if (!pressed) begin
               state_next = REL_CHK;
               cnt_next   = '0;
            end else begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
               if (cnt_inc == RPT_FIRE) begin
                  cnt_next = RPT_RELOAD;
                  rpt_drop = 1'b1;
               end else begin
                  cnt_next = cnt_inc;
               end
`else
               cnt_next = cnt_reg;
`endif
            end
         end
         REL_CHK: begin
            if (pressed) begin
               state_next = PRESSED;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = RELEASED;
               cnt_next   = '0;
            end else begin
               cnt_next   = cnt_inc;
            end
         end
         default: begin
            state_next = RELEASED;
            cnt_next   = '0;
         end
      endcase

      // Outputs decode the next state so they register alongside it.
      db_next       = (state_next == PRESSED) || (state_next == REL_CHK);
      bouncing_next = (state_next == PRESS_CHK) || (state_next == REL_CHK);
`ifdef KEY_DEBOUNCE_REPEAT_EN
      if (rpt_drop) begin
         db_next = 1'b0;
      end
`endif
   end

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state_reg    <= RELEASED;
         cnt_reg      <= '0;
         db_reg       <= 1'b0;
         bouncing_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         db_reg       <= db_next;
         bouncing_reg <= bouncing_next;
      end
   end

   assign kif.Db       = db_reg;
   assign kif.Bouncing = bouncing_reg;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2,
// REPEAT_DELAY=10, REPEAT_PERIOD=3; repeat expectations follow KEY_DEBOUNCE_REPEAT_EN.
module tb_key_debouncer;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   key_debouncer_if kif();

   key_debouncer #(
      .DEBOUNCE_CYCLES (4),
      .SYNC_STAGES     (2),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (3)
   ) dut (
      .Clk    (clk),
      .ResetN (rst_n),
      .kif    (kif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Db level expected j edges after Db first rose, with the key still held.
   function automatic logic exp_hold(input int j);
`ifdef KEY_DEBOUNCE_REPEAT_EN
      return !(j >= 10 && ((j - 10) % 3) == 0);
`else
      return 1'b1;
`endif
   endfunction

   // Clean edge: Db flips at edge 7, Bouncing high on edges 3..6.
   task automatic clean_edge(input string name, input logic db_before);
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("%s_db_k%0d", name, k), kif.Db, (k >= 7) ? ~db_before : db_before);
         check($sformatf("%s_bnc_k%0d", name, k), kif.Bouncing, (k >= 3 && k <= 6));
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      kif.KeyN = 1'b0;

      // Reset held with key pressed: outputs stay low.
      for (int k = 0; k < 3; k++) begin
         tick();
         check("rst_db", kif.Db, 1'b0);
         check("rst_bnc", kif.Bouncing, 1'b0);
      end
      rst_n = 1'b1;
      clean_edge("rst_release_press", 1'b0);
      $display("txn reset_release: key held through reset, Db=%b", kif.Db);

      kif.KeyN = 1'b1;
      clean_edge("release1", 1'b1);
      $display("txn release1: Db=%b", kif.Db);
      repeat (3) tick();

      // Clean press, long hold (auto-repeat window), then release.
      kif.KeyN = 1'b0;
      clean_edge("press2", 1'b0);
      for (int j = 2; j <= 30; j++) begin
         tick();
         check($sformatf("hold_db_j%0d", j), kif.Db, exp_hold(j));
      end
      kif.KeyN = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k <= 2) check($sformatf("rel2_db_k%0d", k), kif.Db, exp_hold(30 + k));
         else        check($sformatf("rel2_db_k%0d", k), kif.Db, (k < 7));
         check($sformatf("rel2_bnc_k%0d", k), kif.Bouncing, (k >= 3 && k <= 6));
      end
      $display("txn press_hold_release: Db=%b", kif.Db);
      repeat (3) tick();

      // Bounce: toggle every 2 cycles for 20 cycles, Db must never rise.
      for (int t = 0; t < 20; t++) begin
         kif.KeyN = ((t / 2) % 2 == 0) ? 1'b0 : 1'b1;
         tick();
         check($sformatf("bounce_db_t%0d", t), kif.Db, 1'b0);
      end
      kif.KeyN = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("bounce_tail_db_k%0d", k), kif.Db, (k >= 7));
      end
      kif.KeyN = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("bounce_rel_db_k%0d", k), kif.Db, (k < 7));
      end
      $display("txn bounce: Db=%b", kif.Db);
      repeat (3) tick();

      // Glitch: 3-cycle low pulse is rejected.
      kif.KeyN = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (k == 4) kif.KeyN = 1'b1;
         tick();
         check($sformatf("glitch_db_k%0d", k), kif.Db, 1'b0);
         check($sformatf("glitch_bnc_k%0d", k), kif.Bouncing, (k >= 3 && k <= 5));
      end
      $display("txn glitch: Db=%b Bouncing=%b", kif.Db, kif.Bouncing);

      // Reset during PRESS_CHK.
      kif.KeyN = 1'b0;
      repeat (4) tick();
      check("pchk_pre_bnc", kif.Bouncing, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("pchk_rst_db", kif.Db, 1'b0);
      check("pchk_rst_bnc", kif.Bouncing, 1'b0);
      tick();
      rst_n = 1'b1;
      clean_edge("pchk_recover", 1'b0);
      $display("txn reset_in_press_chk: Db=%b", kif.Db);

      // Reset during PRESSED: Db drops immediately, no pulse on release of reset.
      check("pressed_pre_db", kif.Db, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("pressed_rst_db", kif.Db, 1'b0);
      tick();
      check("pressed_rst_hold_db", kif.Db, 1'b0);
      kif.KeyN = 1'b1;
      rst_n    = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         check($sformatf("post_rst_db_k%0d", k), kif.Db, 1'b0);
         check($sformatf("post_rst_bnc_k%0d", k), kif.Bouncing, 1'b0);
      end
      $display("txn reset_in_pressed: Db=%b", kif.Db);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
